mem_responder: RTL and testbench

- Memory-side responder for the cache-to-main-memory interface. It serves the cache's refill reads and write-through stores over a valid/ready request and response handshake.
- The access latency is programmable. A word-organised backing array holds the data.
- Sub-word stores (sb/sh) are merged in place, so the cache can forward them without invalidating its line.
- Replaces the zero-latency combinational main memory so cache stall/miss paths get exercised.

---
 rtl/mem_responder_if.sv | 24 ++
 rtl/mem_responder.sv | 131 +++++++++++++
 tb/tb_mem_responder.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_responder_if.sv
// Request/response handshake bundle between the cache (master) and the
// memory-side responder (slave).
interface mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_write;
    logic [31:0] req_wdata;
    logic [2:0]  req_mask;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_addr, req_write, req_wdata, req_mask, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_addr, req_write, req_wdata, req_mask, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/mem_responder.sv
// Main-memory responder: word array with sub-word store merge; response LATENCY edges after acceptance.
// One request in flight; response holds until resp_ready, req_ready only in IDLE.
module mem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 4
) (
    input  logic           clk,
    input  logic           reset,
    mem_responder_if.slave bus
);
    localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic        write_q, write_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  mask_q, mask_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    // Contents survive reset; only the power-up image is zero.
    logic [31:0] mem_q [DEPTH_WORDS] = '{default: '0};

    logic [AW-1:0] idx;
    logic          in_range;
    logic          acc_err;
    logic          commit;
    logic          mem_we;
    logic [31:0]   cur_word;
    logic [31:0]   new_word;

    // Access decode on the latched request: error check and read-modify-write merge.
    always_comb begin
        idx      = addr_q[AW+1:2];
        in_range = ({2'b00, addr_q[31:2]} < DEPTH_WORDS);
        cur_word = in_range ? mem_q[idx] : '0;
        new_word = cur_word;
        acc_err  = !in_range;
        if (write_q) begin
            case (mask_q)
                3'b000: new_word[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
                3'b001: begin
                    if (addr_q[0]) acc_err = 1'b1;
                    new_word[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
                end
                3'b010: begin
                    if (addr_q[1:0] != 2'b00) acc_err = 1'b1;
                    new_word = wdata_q;
                end
                default: acc_err = 1'b1;
            endcase
        end
        commit = (state_q == WAIT) && (cnt_q == 8'd0);
        mem_we = commit && write_q && !acc_err;
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem_q[idx] <= new_word;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        write_d = write_q;
        wdata_d = wdata_q;
        mask_d  = mask_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    addr_d  = bus.req_addr;
                    write_d = bus.req_write;
                    wdata_d = bus.req_wdata;
                    mask_d  = bus.req_mask;
                    cnt_d   = 8'(LATENCY - 1);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    err_d   = acc_err;
                    rdata_d = (!write_q && !acc_err) ? cur_word : 32'h0;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (bus.resp_ready) begin
                    rdata_d = 32'h0;
                    err_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            mask_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
            mask_q  <= mask_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // req_ready is gated by reset so it reads 0 while reset is held.
    assign bus.req_ready  = (state_q == IDLE) && reset;
    assign bus.resp_valid = (state_q == RESP);
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;
endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed scenarios plus random traffic against a byte-lane reference model.
module tb_mem_responder;
    localparam int LAT = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   errors = 0;
    int   checks = 0;

    logic [31:0] ref_mem [1024];

    mem_responder_if bus4();
    mem_responder_if bus1();

    mem_responder #(.DEPTH_WORDS(1024), .LATENCY(LAT)) dut (
        .clk(clk), .reset(reset), .bus(bus4.slave)
    );

    mem_responder #(.DEPTH_WORDS(1024), .LATENCY(1)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: spec rules applied with shifts and masks on a plain word array.
    task automatic model_access(input logic [31:0] a, input logic w, input logic [31:0] d,
                                input logic [2:0] m, output logic e, output logic [31:0] r);
        int unsigned word;
        int sh;
        word = a >> 2;
        e = 1'b0;
        r = 32'h0;
        if (word >= 1024) begin
            e = 1'b1;
        end else if (w) begin
            if (m == 3'd0) begin
                sh = 8 * int'(a[1:0]);
                ref_mem[word] = (ref_mem[word] & ~(32'hFF << sh)) | ((d & 32'hFF) << sh);
            end else if (m == 3'd1) begin
                if (a[0]) e = 1'b1;
                else begin
                    sh = 16 * int'(a[1]);
                    ref_mem[word] = (ref_mem[word] & ~(32'hFFFF << sh)) | ((d & 32'hFFFF) << sh);
                end
            end else if (m == 3'd2) begin
                if (a[1:0] != 2'b00) e = 1'b1;
                else ref_mem[word] = d;
            end else begin
                e = 1'b1;
            end
        end else begin
            r = ref_mem[word];
        end
    endtask

    task automatic send(input logic [31:0] a, input logic w, input logic [31:0] d, input logic [2:0] m);
        int n;
        n = 0;
        while (bus4.req_ready !== 1'b1 && n < 100) begin
            @(posedge clk); #1; n++;
        end
        chk("req_ready_before_send", {31'h0, bus4.req_ready}, 32'h1);
        bus4.req_valid = 1'b1;
        bus4.req_addr  = a;
        bus4.req_write = w;
        bus4.req_wdata = d;
        bus4.req_mask  = m;
        @(posedge clk); #1;
        bus4.req_valid = 1'b0;
    endtask

    task automatic wait_resp(output int lat);
        lat = 0;
        while (bus4.resp_valid !== 1'b1 && lat < 600) begin
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic finish_resp(input string tag);
        bus4.resp_ready = 1'b1;
        @(posedge clk); #1;
        bus4.resp_ready = 1'b0;
        chk({tag, "_post_valid"}, {31'h0, bus4.resp_valid}, 32'h0);
        chk({tag, "_post_rdata"}, bus4.resp_rdata, 32'h0);
        chk({tag, "_post_err"}, {31'h0, bus4.resp_err}, 32'h0);
        chk({tag, "_post_ready"}, {31'h0, bus4.req_ready}, 32'h1);
    endtask

    task automatic xact(input string tag, input logic [31:0] a, input logic w, input logic [31:0] d,
                        input logic [2:0] m, input int hold, output logic [31:0] rd, output logic er);
        logic        e;
        logic [31:0] r;
        int          lat;
        send(a, w, d, m);
        wait_resp(lat);
        chk({tag, "_lat"}, 32'(lat), 32'(LAT));
        model_access(a, w, d, m, e, r);
        chk({tag, "_err"}, {31'h0, bus4.resp_err}, {31'h0, e});
        chk({tag, "_rdata"}, bus4.resp_rdata, r);
        rd = bus4.resp_rdata;
        er = bus4.resp_err;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk({tag, "_hold_valid"}, {31'h0, bus4.resp_valid}, 32'h1);
            chk({tag, "_hold_rdata"}, bus4.resp_rdata, r);
        end
        finish_resp(tag);
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        logic [31:0] hold_val;
        logic [31:0] a;
        logic [2:0]  m;
        logic        e;
        logic [31:0] r;
        int          lat;

        for (int i = 0; i < 1024; i++) ref_mem[i] = 32'h0;
        bus4.req_valid = 0; bus4.req_addr = 0; bus4.req_write = 0;
        bus4.req_wdata = 0; bus4.req_mask = 0; bus4.resp_ready = 0;
        bus1.req_valid = 0; bus1.req_addr = 0; bus1.req_write = 0;
        bus1.req_wdata = 0; bus1.req_mask = 3'd2; bus1.resp_ready = 0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", {31'h0, bus4.req_ready}, 32'h0);
        chk("rst_resp_valid", {31'h0, bus4.resp_valid}, 32'h0);
        chk("rst_resp_rdata", bus4.resp_rdata, 32'h0);
        chk("rst_resp_err", {31'h0, bus4.resp_err}, 32'h0);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("idle_req_ready", {31'h0, bus4.req_ready}, 32'h1);

        // Word store then load
        xact("st_w10", 32'h10, 1'b1, 32'hDEADBEEF, 3'd2, 0, rd, er);
        xact("ld_10", 32'h10, 1'b0, 32'h0, 3'd2, 0, rd, er);
        chk("ld_10_const", rd, 32'hDEADBEEF);

        // Sub-word merge
        xact("st_w20", 32'h20, 1'b1, 32'h11223344, 3'd2, 0, rd, er);
        xact("st_b22", 32'h22, 1'b1, 32'h000000AA, 3'd0, 0, rd, er);
        xact("st_h20", 32'h20, 1'b1, 32'h0000BEEF, 3'd1, 0, rd, er);
        xact("ld_20", 32'h20, 1'b0, 32'h0, 3'd2, 0, rd, er);
        chk("merge_const", rd, 32'h11AABEEF);

        // Error cases
        xact("ld_oor", 32'h1000, 1'b0, 32'h0, 3'd2, 0, rd, er);
        chk("ld_oor_const", {31'h0, er}, 32'h1);
        xact("st_h21", 32'h21, 1'b1, 32'h5555, 3'd1, 0, rd, er);
        chk("st_h21_const", {31'h0, er}, 32'h1);
        xact("st_w22", 32'h22, 1'b1, 32'h66666666, 3'd2, 0, rd, er);
        chk("st_w22_const", {31'h0, er}, 32'h1);
        xact("st_m3", 32'h20, 1'b1, 32'h77777777, 3'd3, 0, rd, er);
        chk("st_m3_const", {31'h0, er}, 32'h1);
        xact("ld_20_again", 32'h20, 1'b0, 32'h0, 3'd2, 0, rd, er);
        chk("unchanged_const", rd, 32'h11AABEEF);

        // Backpressure: response held 5 cycles while a second request waits
        xact("st_w40", 32'h40, 1'b1, 32'hCAFEF00D, 3'd2, 0, rd, er);
        send(32'h40, 1'b0, 32'h0, 3'd2);
        wait_resp(lat);
        chk("bp_a_lat", 32'(lat), 32'(LAT));
        chk("bp_a_rdata", bus4.resp_rdata, 32'hCAFEF00D);
        model_access(32'h40, 1'b0, 32'h0, 3'd2, e, r);
        hold_val = bus4.resp_rdata;
        bus4.req_valid = 1'b1; bus4.req_addr = 32'h10; bus4.req_write = 1'b0; bus4.req_mask = 3'd2;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_hold_valid", {31'h0, bus4.resp_valid}, 32'h1);
            chk("bp_hold_rdata", bus4.resp_rdata, hold_val);
            chk("bp_hold_req_ready", {31'h0, bus4.req_ready}, 32'h0);
        end
        bus4.resp_ready = 1'b1;
        @(posedge clk); #1;
        bus4.resp_ready = 1'b0;
        chk("bp_hs_valid", {31'h0, bus4.resp_valid}, 32'h0);
        chk("bp_hs_req_ready", {31'h0, bus4.req_ready}, 32'h1);
        @(posedge clk); #1;
        bus4.req_valid = 1'b0;
        chk("bp_b_accepted", {31'h0, bus4.req_ready}, 32'h0);
        wait_resp(lat);
        chk("bp_b_lat", 32'(lat), 32'(LAT));
        chk("bp_b_rdata", bus4.resp_rdata, 32'hDEADBEEF);
        finish_resp("bp_b");

        // Reset in the middle of WAIT drops an uncommitted store
        send(32'h30, 1'b1, 32'h12345678, 3'd2);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        chk("mid_rst_req_ready", {31'h0, bus4.req_ready}, 32'h0);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            chk("mid_rst_valid", {31'h0, bus4.resp_valid}, 32'h0);
        end
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("post_rst_valid", {31'h0, bus4.resp_valid}, 32'h0);
        end
        xact("ld_30", 32'h30, 1'b0, 32'h0, 3'd2, 0, rd, er);
        chk("ld_30_const", rd, 32'h0);

        // Random traffic
        for (int t = 0; t < 80; t++) begin
            if ($urandom_range(0, 7) == 0) a = 32'h1000 + ($urandom & 32'h7FFFFFFF);
            else a = 32'($urandom_range(0, 255));
            m = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) != 0) m = 3'($urandom_range(0, 2));
            if ($urandom_range(0, 3) == 0) a = {a[31:2], 2'b00};
            xact("rnd", a, 1'($urandom_range(0, 1)), $urandom, m, $urandom_range(0, 3), rd, er);
        end

        // LATENCY=1 instance: back-to-back loads with resp_ready tied high
        bus1.resp_ready = 1'b1;
        bus1.req_addr = 32'h8;
        bus1.req_valid = 1'b1;
        chk("l1_ready_start", {31'h0, bus1.req_ready}, 32'h1);
        for (int i = 0; i < 9; i++) begin
            chk("l1_req_ready", {31'h0, bus1.req_ready}, {31'h0, (i % 3) == 0});
            chk("l1_resp_valid", {31'h0, bus1.resp_valid}, {31'h0, (i % 3) == 2});
            chk("l1_resp_err", {31'h0, bus1.resp_err}, 32'h0);
            @(posedge clk); #1;
        end
        bus1.req_valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
